gold_seq_gen: RTL and testbench

- Generates the 31-bit PUSCH DMRS hopping pseudo-random window: c(n), n=0..30, of the 38.211 §5.2.1 length-31 Gold sequence.
- Writer side of the pseudo_sequence bus; the DMRS u/v parameter generator reads this bus.
- c_init is selected by hopping mode: group hopping uses floor(N_cell_ID/30); sequence hopping uses N_cell_ID.
- Runs the Nc=1600 warm-up, collects 31 output bits, then publishes them with a done pulse.

---
 rtl/pusch_dmrs_pkg.sv | 32 +++
 rtl/div30_const.sv | 15 +
 rtl/gold_seq_gen.sv | 152 +++++++++++++++
 tb/tb_gold_seq_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pusch_dmrs_pkg.sv
// Shared definitions for the PUSCH DMRS generator blocks.
//   - hopping mode codes carried on En_hopping
//   - Gold sequence constants (warm-up offset, window length)
//   - sequence generator FSM state encoding
//   - single-step update functions for the two Gold m-sequences
package pusch_dmrs_pkg;

  localparam logic [1:0] HOP_DIS = 2'd0;
  localparam logic [1:0] HOP_GH  = 2'd1;
  localparam logic [1:0] HOP_SH  = 2'd2;

  localparam int NC          = 1600;
  localparam int SEQ_LEN     = 31;
  localparam int N_SYMB_SLOT = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COLLECT = 2'd2
  } state_e;

  // x1(n+31) = x1(n+3) + x1(n); bit 0 is the oldest element.
  function automatic logic [30:0] x1_step(input logic [30:0] x);
    return {x[3] ^ x[0], x[30:1]};
  endfunction

  // x2(n+31) = x2(n+3) + x2(n+2) + x2(n+1) + x2(n)
  function automatic logic [30:0] x2_step(input logic [30:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
  endfunction

endpackage

// File: rtl/div30_const.sv
// Combinational floor(id/30) for a 10-bit id.
//   id : input 0..1023
//   q  : floor(id/30), 0..34
// Reciprocal multiply by 1093/2^15. The reciprocal overshoots 1/30 by
// ~2.2e-5, i.e. at most 0.023 over the full input range, which is smaller
// than the 1/30 headroom left by the largest fractional part (29/30), so
// the truncated result is exact for every input.
module div30_const (
  input  logic [9:0] id,
  output logic [5:0] q
);

  assign q = 6'(({11'b0, id} * 21'd1093) >> 15);

endmodule

// File: rtl/gold_seq_gen.sv
// Length-31 Gold sequence window generator for PUSCH DMRS hopping.
// Seeds x1/x2 from the hopping-mode c_init, runs the NC-step warm-up at
// WARM_P steps per clock, then collects c(0)..c(30) one bit per clock and
// publishes the whole window with a one-cycle done pulse.
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   start           : request a run (honoured only in IDLE)
//   N_cell_ID       : cell/scrambling ID, sampled at the accepted start
//   En_hopping      : 1=group hopping, 2=sequence hopping, else disabled
//   pseudo_sequence : bit n = c(n); only updated on the done edge
//   busy            : high from accepted start until the done edge
//   done            : one-cycle pulse, pseudo_sequence valid from here
module gold_seq_gen
  import pusch_dmrs_pkg::*;
#(
  parameter int WARM_P  = 8,  // 1,2,4,8,16: must divide NC and stay below tap distance 28
  parameter int NC      = pusch_dmrs_pkg::NC,
  parameter int SEQ_LEN = pusch_dmrs_pkg::SEQ_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [9:0]          N_cell_ID,
  input  logic [1:0]          En_hopping,
  output logic [SEQ_LEN-1:0]  pseudo_sequence,
  output logic                busy,
  output logic                done
);

  localparam int W      = NC / WARM_P;
  localparam int CNT_MX = (W > SEQ_LEN) ? W : SEQ_LEN;
  localparam int CNT_W  = $clog2(CNT_MX + 1);
  localparam int IDX_W  = $clog2(SEQ_LEN);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(SEQ_LEN - 1);

  state_e             state, state_nxt;
  logic [30:0]        x1, x2;
  logic [30:0]        x1_w, x2_w;
  logic [CNT_W-1:0]   cnt;
  logic [SEQ_LEN-1:0] collect, collect_nxt;
  logic [5:0]         id_div30;
  logic [9:0]         c_init;
  logic               hop_en;
  logic               c_bit;

  // control strobes from the output decode
  logic ld, dis, warm, col, fin;

  div30_const u_div30 (
    .id (N_cell_ID),
    .q  (id_div30)
  );

  assign hop_en = (En_hopping == HOP_GH) || (En_hopping == HOP_SH);
  assign c_init = (En_hopping == HOP_GH) ? {4'b0, id_div30} : N_cell_ID;
  assign c_bit  = x1[0] ^ x2[0];

  // WARM_P chained steps per warm-up clock; WARM_P < 28 keeps every new
  // bit a function of bits already in the register.
  always_comb begin
    x1_w = x1;
    x2_w = x2;
    for (int i = 0; i < WARM_P; i++) begin
      x1_w = x1_step(x1_w);
      x2_w = x2_step(x2_w);
    end
  end

  always_comb begin
    collect_nxt = collect;
    collect_nxt[cnt[IDX_W-1:0]] = c_bit;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start && hop_en)   state_nxt = ST_WARMUP;
      ST_WARMUP:  if (cnt == WARM_LAST)  state_nxt = ST_COLLECT;
      ST_COLLECT: if (cnt == COL_LAST)   state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // FSM: output decode
  always_comb begin
    ld   = 1'b0;
    dis  = 1'b0;
    warm = 1'b0;
    col  = 1'b0;
    fin  = 1'b0;
    case (state)
      ST_IDLE: begin
        ld  = start &&  hop_en;
        dis = start && !hop_en;
      end
      ST_WARMUP:  warm = 1'b1;
      ST_COLLECT: begin
        col = 1'b1;
        fin = (cnt == COL_LAST);
      end
      default: ;
    endcase
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1              <= '0;
      x2              <= '0;
      cnt             <= '0;
      collect         <= '0;
      pseudo_sequence <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        x1   <= 31'h1;
        x2   <= {21'b0, c_init};
        cnt  <= '0;
        busy <= 1'b1;
      end else if (dis) begin
        pseudo_sequence <= '0;
        done            <= 1'b1;
      end else if (warm) begin
        x1  <= x1_w;
        x2  <= x2_w;
        cnt <= (cnt == WARM_LAST) ? '0 : cnt + 1'b1;
      end else if (col) begin
        collect <= collect_nxt;
        x1      <= x1_step(x1);
        x2      <= x2_step(x2);
        cnt     <= fin ? '0 : cnt + 1'b1;
        if (fin) begin
          pseudo_sequence <= collect_nxt;
          done            <= 1'b1;
          busy            <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gold_seq_gen.sv
module tb_gold_seq_gen;

  parameter int WARM_P = 8;
  localparam int NC_M = 1600;
  localparam int LAT  = NC_M / WARM_P + 31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  N_cell_ID = '0;
  logic [1:0]  En_hopping = '0;
  logic [30:0] pseudo_sequence;
  logic        busy, done;

  gold_seq_gen #(.WARM_P(WARM_P)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .N_cell_ID       (N_cell_ID),
    .En_hopping      (En_hopping),
    .pseudo_sequence (pseudo_sequence),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] seq;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0;
  int          n_done = 0, issued = 0, busy_cnt = 0;
  logic        prev_done = 1'b0;
  logic [30:0] last_seq = '0;

  // Reference: 38.211 recursion written on plain bit arrays.
  function automatic logic [30:0] gold(input logic [30:0] cinit);
    logic a[0:NC_M+30];
    logic b[0:NC_M+30];
    logic [30:0] c;
    for (int i = 0; i < 31; i++) begin
      a[i] = (i == 0);
      b[i] = cinit[i];
    end
    for (int n = 0; n < NC_M; n++) begin
      a[n+31] = a[n+3] ^ a[n];
      b[n+31] = b[n+3] ^ b[n+2] ^ b[n+1] ^ b[n];
    end
    for (int n = 0; n < 31; n++) c[n] = a[n+NC_M] ^ b[n+NC_M];
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Called a little after a falling edge; start is seen on the next rise.
  task automatic issue(input logic [1:0] hop, input logic [9:0] id);
    exp_t  e;
    logic  en;
    en = (hop == 2'd1) || (hop == 2'd2);
    e.seq = en ? gold((hop == 2'd1) ? 31'(id / 30) : 31'(id)) : 31'h0;
    e.lat = en ? LAT : 0;
    sb.push_back(e);
    issued++;
    start = 1'b1; En_hopping = hop; N_cell_ID = id;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; En_hopping = 2'd2; N_cell_ID = 10'd5;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bool_loop: begin
      for (int k = 0; k < 3000; k++) begin
        if (n_done >= issued) disable bool_loop;
        @(negedge clk); #1;
      end
      checks++; failures++;
      $display("FAIL done_timeout actual=%0d expected=%0d", n_done, issued);
      issued = n_done;
    end
  endtask

  // Monitor / scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        check("done_width", 64'(prev_done), 64'd0);
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          check("pseudo_sequence", 64'(pseudo_sequence), 64'(e.seq));
          check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
          last_seq = e.seq;
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  logic [1:0] t_hop [13] = '{2'd1, 2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd2,
                             2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
  logic [9:0] t_id  [13] = '{10'd100, 10'd100, 10'd5, 10'd0, 10'd29, 10'd30, 10'd1,
                             10'd1023, 10'd1023, 10'd59, 10'd60, 10'd0, 10'd899};

  initial begin
    #1 rst_n = 1'b0;
    cyc(3);
    check("reset_seq", 64'(pseudo_sequence), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 13; i++) begin
      issue(t_hop[i], t_id[i]);
      wait_done();
      cyc(2);
    end

    // starts during a run are ignored; output holds the previous window
    issue(2'd1, 10'd500);
    cyc(3);  pulse_start();
    cyc(44); pulse_start();
    cyc(98);
    check("hold_mid_run", 64'(pseudo_sequence), 64'(last_seq));
    pulse_start();
    wait_done();
    cyc(2);

    // start in the done cycle is accepted
    issue(2'd1, 10'd7);
    wait_done();
    issue(2'd2, 10'd77);
    cyc(100);
    check("hold_back_to_back", 64'(pseudo_sequence), 64'(last_seq));
    wait_done();
    cyc(2);

    // reset in the middle of warm-up
    issue(2'd1, 10'd200);
    cyc(99);
    rst_n = 1'b0;
    #1;
    check("midrst_seq", 64'(pseudo_sequence), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    sb.delete();
    issued   = n_done;
    last_seq = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(LAT + 10);
    issue(2'd1, 10'd200);
    wait_done();

    cyc(5);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
